booth_mult_arbiter: RTL and testbench
=====================================

# booth_mult_arbiter

Round-robin arbiter that shares one `booth_multiplier_16` instance between NREQ independent requesters, such as several Winograd tile engines or a filter-transform unit. It captures the winning requester's operands and generates the multiplier's start pulse. It waits for the multiplier's done, then returns the 32-bit signed product to the granted requester with a one-cycle response strobe. It sits between the requesters and the single shared multiplier, and owns all of that multiplier's control inputs.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: maximum number of WAIT cycles before an abort. Only used when `BMA_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  request, one bit per requester, level.
- `req_a`  in  16*NREQ  signed multiplicands. Requester i uses bits [16i+15:16i].
- `req_b`  in  16*NREQ  signed multipliers, packed the same way as `req_a`.
- `gnt`  out  NREQ  one-hot, one-cycle operand-accepted pulse.
- `rsp_valid`  out  NREQ  one-hot, one-cycle result pulse.
- `rsp_product`  out  32  signed product, broadcast to all requesters. Qualified by `rsp_valid`.
- `rsp_err`  out  1  timeout flag. Qualified by `rsp_valid`.
- `busy`  out  1  high in every state except IDLE.
- `mult_start`  out  1  start pulse to the multiplier.
- `mult_a`  out  16  multiplicand to the multiplier.
- `mult_b`  out  16  multiplier operand to the multiplier.
- `mult_product`  in  32  product from the multiplier.
- `mult_done`  in  1  done from the multiplier.

## Operation
- The FSM has four states: IDLE, GRANT, LAUNCH, WAIT.
- **IDLE**, when some `req` bit is high:
  - Choose the winner i, round-robin: the first set bit searching upward from `last+1`, modulo NREQ.
  - Capture `req_a[i]` into `mult_a` and `req_b[i]` into `mult_b`.
  - Set `gnt[i]` for one cycle, set `last <= i`, go to GRANT.
- **GRANT**: deassert `gnt`, assert `mult_start`, go to LAUNCH.
- **LAUNCH**: deassert `mult_start`, clear the WAIT counter, go to WAIT.
- **WAIT**, on `mult_done`:
  - `rsp_product <= mult_product`, `rsp_err <= 0`.
  - `rsp_valid[last]` is high for one cycle.
  - Go to IDLE.
- `mult_done` is ignored in IDLE, GRANT and LAUNCH. This discards a stale done left over from the previous operation.
- `mult_a` and `mult_b` hold their values from capture until the next grant.
- Requester protocol:
  - Hold `req` high with stable operands until `gnt` is seen.
  - `req` may stay high after `gnt`. That is a new request, arbitrated on the next IDLE visit.
  - A `req` that drops before `gnt` is simply not served. No error is raised.
- Arithmetic:
  - No transformation of operands or product; the 32-bit product is passed through unchanged.
  - Operand capture is bit-exact, so signs are preserved.
- Reset, including reset in the middle of an operation:
  - Forces IDLE. `gnt`, `rsp_valid`, `rsp_err`, `busy` and `mult_start` go to 0.
  - `rsp_product`, `mult_a` and `mult_b` go to 0.
  - `last` goes to NREQ-1, so requester 0 wins the first arbitration.
  - Any in-flight operation is dropped with no response. The multiplier shares `rst`.

## Timing
- Edge E0: IDLE samples a request. After E0, `gnt` is high and the operands are valid.
- After E1: `mult_start` is high for exactly one cycle.
- WAIT begins after E2.
- Edge En: WAIT samples `mult_done` high. After En, `rsp_valid` is high for one cycle and the FSM is in IDLE.
- The earliest next grant is at En+1. Minimum gap between grants is therefore 3 cycles plus the multiplier latency plus 1.
- `busy` is 0 only in IDLE. It is registered together with the state.
- If `req` and `mult_done` change on the same edge, each is handled according to the current state only.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- Macro: `BMA_TIMEOUT_EN`.
- **Defined**:
  - A counter of ceil(log2(TIMEOUT+1)) bits increments in every WAIT cycle.
  - When it reaches TIMEOUT without `mult_done`, the FSM returns to IDLE.
  - On that return: `rsp_valid[last]=1`, `rsp_err=1`, `rsp_product=0`.
  - `mult_done` arriving in the same cycle as the timeout wins, with `rsp_err=0`.
- **Undefined**:
  - No counter is built. WAIT lasts until `mult_done`, however long that takes.
  - `rsp_err` is tied to 0.

## Test plan
- Reset, then `req=4'b0001`, a=3, b=-7 → `gnt=0001` after 1 cycle, one `mult_start` pulse, then `rsp_valid=0001` with `rsp_product=-21` and `rsp_err=0`.
- `req=4'b1111` held for 8 transactions → grant order 0,1,2,3,0,1,2,3. Each `rsp_valid` matches its grant. Products correct for a=i+1, b=-(i+2).
- Boundary operands a=-32768, b=-32768 → `rsp_product=32'h40000000`. a=32767, b=-32768 → `rsp_product=32'hC0008000`.
- `rst` asserted during WAIT → all outputs 0 immediately, no `rsp_valid`. The next `req=0010` is granted to requester 1 in the first IDLE cycle after reset.
- Stub multiplier holding `mult_done` high across back-to-back operations → no response before WAIT, exactly one `rsp_valid` per grant.
- `BMA_TIMEOUT_EN` defined, TIMEOUT=64, stub never asserts done → `rsp_valid` with `rsp_err=1` and `rsp_product=0` after 64 WAIT cycles, then the FSM returns to IDLE and serves the next request.

Source files
------------

// File: rtl/booth_mult_arbiter.sv
// Round-robin share of one 16x16 signed multiplier among NREQ requesters; optional WAIT watchdog via BMA_TIMEOUT_EN.
// Latency: gnt 1 cycle after a sampled req, rsp_valid 1 cycle after mult_done is seen in WAIT.
// Backpressure: requesters hold req and operands until gnt; only one operation is in flight.
module booth_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [31:0]        rsp_product,
    output logic               rsp_err,
    output logic               busy,
    output logic               mult_start,
    output logic [15:0]        mult_a,
    output logic [15:0]        mult_b,
    input  logic [31:0]        mult_product,
    input  logic               mult_done
);
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("booth_mult_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_LAUNCH, S_WAIT} state_t;

    state_t          state, state_nxt;
    logic [LW-1:0]   last, last_nxt;
    logic [NREQ-1:0] gnt_nxt, rsp_valid_nxt;
    logic [31:0]     rsp_product_nxt;
    logic [15:0]     mult_a_nxt, mult_b_nxt;
    logic            mult_start_nxt;
    logic            win_found;
    int              win_int;

`ifdef BMA_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt, wait_cnt_nxt;
    logic          rsp_err_nxt;
`endif

    // Search upward from last+1 so the previous winner has lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_int   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (int'(last) + k) % NREQ;
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_int   = idx;
            end
        end
    end

    always_comb begin
        state_nxt       = state;
        last_nxt        = last;
        gnt_nxt         = '0;
        rsp_valid_nxt   = '0;
        rsp_product_nxt = rsp_product;
        mult_start_nxt  = 1'b0;
        mult_a_nxt      = mult_a;
        mult_b_nxt      = mult_b;
`ifdef BMA_TIMEOUT_EN
        wait_cnt_nxt    = wait_cnt;
        rsp_err_nxt     = rsp_err;
`endif
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    gnt_nxt[win_int] = 1'b1;
                    mult_a_nxt       = req_a[16*win_int +: 16];
                    mult_b_nxt       = req_b[16*win_int +: 16];
                    last_nxt         = LW'(win_int);
                    state_nxt        = S_GRANT;
                end
            end
            S_GRANT: begin
                mult_start_nxt = 1'b1;
                state_nxt      = S_LAUNCH;
            end
            S_LAUNCH: begin
`ifdef BMA_TIMEOUT_EN
                wait_cnt_nxt = '0;
`endif
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mult_done) begin
                    rsp_product_nxt     = mult_product;
                    rsp_valid_nxt[last] = 1'b1;
                    state_nxt           = S_IDLE;
`ifdef BMA_TIMEOUT_EN
                    rsp_err_nxt         = 1'b0;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    // This cycle is the TIMEOUT-th WAIT cycle without a done.
                    rsp_product_nxt     = '0;
                    rsp_valid_nxt[last] = 1'b1;
                    rsp_err_nxt         = 1'b1;
                    state_nxt           = S_IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + CW'(1);
`endif
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last        <= LW'(NREQ - 1);
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_product <= '0;
            busy        <= 1'b0;
            mult_start  <= 1'b0;
            mult_a      <= '0;
            mult_b      <= '0;
        end else begin
            state       <= state_nxt;
            last        <= last_nxt;
            gnt         <= gnt_nxt;
            rsp_valid   <= rsp_valid_nxt;
            rsp_product <= rsp_product_nxt;
            busy        <= (state_nxt != S_IDLE);
            mult_start  <= mult_start_nxt;
            mult_a      <= mult_a_nxt;
            mult_b      <= mult_b_nxt;
        end
    end

`ifdef BMA_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            rsp_err  <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            rsp_err  <= rsp_err_nxt;
        end
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Bench for booth_mult_arbiter: stub multiplier plus grant/response scoreboard queues.
module tb_booth_mult_arbiter;
    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [63:0] req_a, req_b;
    logic [3:0]  gnt, rsp_valid;
    logic [31:0] rsp_product;
    logic        rsp_err, busy, mult_start;
    logic [15:0] mult_a, mult_b;
    logic [31:0] mult_product;
    logic        mult_done;

    always #5 clk = ~clk;

    booth_mult_arbiter #(.NREQ(NREQ), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product), .rsp_err(rsp_err),
        .busy(busy), .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_product(mult_product), .mult_done(mult_done)
    );

    typedef struct {
        int          idx;
        logic [31:0] prod;
        logic        err;
    } exp_t;

    int   checks = 0, passed = 0;
    int   cyc = 0, gnt_cnt = 0, rsp_cnt = 0, last_gnt_cyc = 0, last_rsp_cyc = 0;
    int   lat = 4, st_cnt;
    bit   hold_mode = 0, never_done = 0;
    int   gnt_q[$];
    exp_t rsp_q[$];
    int   gnt_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Stub multiplier: product latched on start, done after lat cycles, or held high in hold_mode.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            st_cnt       <= 0;
            mult_done    <= 1'b0;
            mult_product <= '0;
        end else begin
            mult_done <= hold_mode;
            if (mult_start) begin
                mult_product <= $signed(mult_a) * $signed(mult_b);
                st_cnt       <= lat;
            end else if (st_cnt > 0) begin
                st_cnt <= st_cnt - 1;
                if (st_cnt == 1 && !never_done) mult_done <= 1'b1;
            end
        end
    end

    // Scoreboard monitor: every grant and response is matched against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != 4'b0) begin
                int eg;
                gnt_cnt++;
                gnt_cyc_q.push_back(cyc);
                last_gnt_cyc = cyc;
                checks++;
                if (gnt_q.size() == 0) begin
                    $display("FAIL gnt_unexpected: got %b, none expected", gnt);
                end else begin
                    eg = gnt_q.pop_front();
                    if (gnt !== 4'(1 << eg)) $display("FAIL gnt_order: got %b want %b", gnt, 4'(1 << eg));
                    else passed++;
                end
            end
            if (rsp_valid != 4'b0) begin
                exp_t e;
                rsp_cnt++;
                last_rsp_cyc = cyc;
                checks++;
                if (rsp_q.size() == 0) begin
                    $display("FAIL rsp_unexpected: got %b, none expected", rsp_valid);
                end else begin
                    passed++;
                    e = rsp_q.pop_front();
                    checks++;
                    if (rsp_valid !== 4'(1 << e.idx)) $display("FAIL rsp_valid: got %b want %b", rsp_valid, 4'(1 << e.idx));
                    else passed++;
                    checks++;
                    if (rsp_product !== e.prod) $display("FAIL rsp_product: got %h want %h", rsp_product, e.prod);
                    else passed++;
                    checks++;
                    if (rsp_err !== e.err) $display("FAIL rsp_err: got %b want %b", rsp_err, e.err);
                    else passed++;
                end
                checks++;
                if (cyc - last_gnt_cyc < 3) $display("FAIL rsp_too_early: %0d cycles after gnt, want >= 3", cyc - last_gnt_cyc);
                else passed++;
            end
        end
    end

    function automatic logic [31:0] mul(input logic [15:0] a, input logic [15:0] b);
        return $signed(a) * $signed(b);
    endfunction

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
    endtask

    task automatic wait_gnt(input int target, input int budget);
        int t = 0;
        while (gnt_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (gnt_cnt < target) $display("FAIL gnt_timeout: got %0d grants want %0d", gnt_cnt, target);
        else passed++;
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int t = 0;
        while (rsp_cnt < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rsp_cnt < target) $display("FAIL rsp_timeout: got %0d responses want %0d", rsp_cnt, target);
        else passed++;
    endtask

    task automatic one_txn(input int i, input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp_p);
        int g0, r0;
        g0 = gnt_cnt;
        r0 = rsp_cnt;
        @(negedge clk);
        set_op(i, a, b);
        gnt_q.push_back(i);
        rsp_q.push_back('{i, exp_p, 1'b0});
        req = 4'(1 << i);
        wait_gnt(g0 + 1, 20);
        req = '0;
        wait_rsp(r0 + 1, 200);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, rsp_valid, rsp_err, busy, mult_start} !== 11'b0)
            $display("FAIL reset_ctrl: got %b want 0", {gnt, rsp_valid, rsp_err, busy, mult_start});
        else passed++;
        checks++;
        if ({mult_a, mult_b, rsp_product} !== 64'b0)
            $display("FAIL reset_data: got %h want 0", {mult_a, mult_b, rsp_product});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, busy, mult_start} !== 6'b0) $display("FAIL idle_after_reset: got %b want 0", {gnt, busy, mult_start});
        else passed++;
    endtask

    task automatic test_single;
        int r0 = rsp_cnt;
        set_op(0, 16'd3, -16'sd7);
        gnt_q.push_back(0);
        rsp_q.push_back('{0, 32'hFFFF_FFEB, 1'b0});
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) $display("FAIL single_gnt: got gnt=%b busy=%b want 0001/1", gnt, busy);
        else passed++;
        checks++;
        if (mult_a !== 16'd3 || mult_b !== 16'hFFF9) $display("FAIL single_ops: got %h/%h want 0003/fff9", mult_a, mult_b);
        else passed++;
        req = '0;
        @(negedge clk);
        checks++;
        if (mult_start !== 1'b1 || gnt !== 4'b0) $display("FAIL single_start: got start=%b gnt=%b want 1/0000", mult_start, gnt);
        else passed++;
        @(negedge clk);
        checks++;
        if (mult_start !== 1'b0) $display("FAIL single_start_pulse: got %b want 0", mult_start);
        else passed++;
        wait_rsp(r0 + 1, 50);
    endtask

    task automatic test_round_robin;
        int g0, r0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'(-(i + 2)));
        g0 = gnt_cnt;
        r0 = rsp_cnt;
        for (int k = 0; k < 8; k++) begin
            gnt_q.push_back(k % 4);
            rsp_q.push_back('{k % 4, mul(16'(k % 4 + 1), 16'(-(k % 4 + 2))), 1'b0});
        end
        req = 4'b1111;
        wait_gnt(g0 + 8, 400);
        req = '0;
        wait_rsp(r0 + 8, 100);
    endtask

    task automatic test_boundaries;
        one_txn(3, 16'h8000, 16'h8000, 32'h4000_0000);
        one_txn(1, 16'h7FFF, 16'h8000, 32'hC000_8000);
    endtask

    task automatic test_reset_in_wait;
        int r0;
        lat = 30;
        @(negedge clk);
        set_op(2, 16'd100, 16'd200);
        gnt_q.push_back(2);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        repeat (5) @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL wait_busy: got %b want 1", busy);
        else passed++;
        r0 = rsp_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_err, busy, mult_start} !== 11'b0)
            $display("FAIL midrst_ctrl: got %b want 0", {gnt, rsp_valid, rsp_err, busy, mult_start});
        else passed++;
        checks++;
        if ({mult_a, mult_b, rsp_product} !== 64'b0)
            $display("FAIL midrst_data: got %h want 0", {mult_a, mult_b, rsp_product});
        else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lat = 4;
        set_op(1, 16'd5, 16'd6);
        gnt_q.push_back(1);
        rsp_q.push_back('{1, 32'd30, 1'b0});
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) $display("FAIL post_rst_gnt: got %b want 0010", gnt);
        else passed++;
        req = '0;
        wait_rsp(r0 + 1, 100);
        repeat (20) @(negedge clk);
        checks++;
        if (rsp_cnt !== r0 + 1) $display("FAIL post_rst_rsp_count: got %0d want %0d", rsp_cnt, r0 + 1);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int g0, r0, n;
        @(negedge clk);
        hold_mode = 1'b1;
        set_op(2, -16'sd3, 16'd9);
        g0 = gnt_cnt;
        r0 = rsp_cnt;
        n  = gnt_cyc_q.size();
        for (int k = 0; k < 3; k++) begin
            gnt_q.push_back(2);
            rsp_q.push_back('{2, -32'sd27, 1'b0});
        end
        repeat (3) @(negedge clk);
        req = 4'b0100;
        wait_gnt(g0 + 3, 100);
        req = '0;
        wait_rsp(r0 + 3, 50);
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (gnt_cyc_q.size() < n + 3) $display("FAIL b2b_gap%0d: missing grants", k);
            else if (gnt_cyc_q[n + k] - gnt_cyc_q[n + k - 1] != 4)
                $display("FAIL b2b_gap%0d: got %0d want 4", k, gnt_cyc_q[n + k] - gnt_cyc_q[n + k - 1]);
            else passed++;
        end
        hold_mode = 1'b0;
        repeat (3) @(negedge clk);
    endtask

`ifdef BMA_TIMEOUT_EN
    task automatic test_timeout;
        int g0, r0;
        never_done = 1'b1;
        g0 = gnt_cnt;
        r0 = rsp_cnt;
        @(negedge clk);
        set_op(3, 16'd7, 16'd7);
        gnt_q.push_back(3);
        rsp_q.push_back('{3, 32'd0, 1'b1});
        req = 4'b1000;
        wait_gnt(g0 + 1, 20);
        req = '0;
        wait_rsp(r0 + 1, 200);
        checks++;
        if (last_rsp_cyc - last_gnt_cyc != 66) $display("FAIL timeout_len: got %0d want 66", last_rsp_cyc - last_gnt_cyc);
        else passed++;
        never_done = 1'b0;
        one_txn(0, 16'd2, 16'd3, 32'd6);
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_boundaries();
        test_reset_in_wait();
        test_back_to_back();
`ifdef BMA_TIMEOUT_EN
        test_timeout();
`endif
        checks++;
        if (gnt_q.size() != 0 || rsp_q.size() != 0)
            $display("FAIL leftover: gnt_q=%0d rsp_q=%0d want 0/0", gnt_q.size(), rsp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
